fir_coeff_loader: RTL and testbench

Streaming coefficient writer for the single-channel systolic FIR. It accepts a framed stream of C_NUM signed Q1.15 coefficients over a valid/ready handshake into a shadow bank. On request it atomically copies a complete, length-checked frame into the active bank that drives the FIR tap coefficients, so the filter never sees a partially written set. It sits between the control/config path and the FIR tap chain, replacing the hard-coded coefficient table.

---
 rtl/fir_coeff_loader_if.sv | 24 ++
 rtl/fir_coeff_loader.sv | 114 +++++++++++
 tb/tb_fir_coeff_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_loader_if.sv
// Coefficient stream bus: one signed coefficient per beat, framed by s_last,
// moved on a valid/ready handshake from the config path into the loader.
interface fir_coeff_loader_if #(
    parameter int C_W = 16
) ();
    logic           s_valid;
    logic           s_ready;
    logic [C_W-1:0] s_data;
    logic           s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// Streaming coefficient loader for the systolic FIR.
// Beats fill a shadow bank. Only a frame of exactly C_NUM beats reaches the
// pending state, and only from there can apply copy the whole shadow bank
// into the active bank in one edge. The taps therefore never see a partial
// set. Every output is a register, so no input reaches an output through
// combinational logic.
module fir_coeff_loader #(
    parameter int C_W   = 16,
    parameter int C_NUM = 33,
    parameter int IDX_W = $clog2(C_NUM)
) (
    input  logic                   clock,
    input  logic                   reset,
    fir_coeff_loader_if.slave      bus,
    input  logic                   apply,
    output logic [C_NUM*C_W-1:0]   coeff_out,
    output logic                   load_done,
    output logic                   err,
    output logic [7:0]             swap_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        PENDING
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM - 1);

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [C_NUM*C_W-1:0]   shadow;
    logic                   ready_q;
    logic                   accept;

    assign bus.s_ready = ready_q;
    assign accept      = bus.s_valid && ready_q;

    // Frame FSM: fills the shadow bank, checks the frame length, and performs the atomic shadow-to-active swap
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            shadow     <= '0;
            coeff_out  <= '0;
            ready_q    <= 1'b1;
            load_done  <= 1'b0;
            err        <= 1'b0;
            swap_count <= 8'd0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shadow[0 +: C_W] <= bus.s_data;
                        if (bus.s_last) begin
                            err <= 1'b1;
                            idx <= '0;
                        end else begin
                            state <= LOAD;
                            idx   <= IDX_W'(1);
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shadow[int'(idx)*C_W +: C_W] <= bus.s_data;
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (bus.s_last) begin
                                state     <= PENDING;
                                ready_q   <= 1'b0;
                                load_done <= 1'b1;
                            end else begin
                                state <= DRAIN;
                            end
                        end else if (bus.s_last) begin
                            state <= IDLE;
                            err   <= 1'b1;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (accept && bus.s_last) begin
                        state <= IDLE;
                        err   <= 1'b1;
                        idx   <= '0;
                    end
                end
                PENDING: begin
                    if (apply) begin
                        coeff_out  <= shadow;
                        swap_count <= swap_count + 8'd1;
                        ready_q    <= 1'b1;
                        load_done  <= 1'b0;
                        idx        <= '0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    ready_q   <= 1'b1;
                    load_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader.
// The reference model works at frame level. It collects the beats of a frame
// in a queue. When s_last arrives, the frame is judged only on its length.
// A pending set is swapped into the active bank when apply is seen while
// pending.
module tb_fir_coeff_loader;

    localparam int C_W   = 16;
    localparam int C_NUM = 33;

    logic                  clock;
    logic                  reset;
    logic                  apply;
    logic [C_NUM*C_W-1:0]  coeffOut;
    logic                  loadDone;
    logic                  err;
    logic [7:0]            swapCount;

    fir_coeff_loader_if #(.C_W(C_W)) bus ();

    fir_coeff_loader #(
        .C_W   (C_W),
        .C_NUM (C_NUM)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .apply      (apply),
        .coeff_out  (coeffOut),
        .load_done  (loadDone),
        .err        (err),
        .swap_count (swapCount)
    );

    int total = 0;
    int bad   = 0;

    logic [C_W-1:0] frameData   [0:63];
    logic [C_W-1:0] frameQ      [$];
    logic [C_W-1:0] modelShadow [0:C_NUM-1];
    logic [C_W-1:0] modelActive [0:C_NUM-1];
    logic           modelPending;
    logic           expErr;
    int             modelSwaps;

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [C_NUM*C_W-1:0] packActive();
        logic [C_NUM*C_W-1:0] v;
        for (int i = 0; i < C_NUM; i++) v[i*C_W +: C_W] = modelActive[i];
        return v;
    endfunction

    task automatic modelReset();
        modelPending = 1'b0;
        expErr       = 1'b0;
        modelSwaps   = 0;
        frameQ.delete();
        for (int i = 0; i < C_NUM; i++) begin
            modelActive[i] = '0;
            modelShadow[i] = '0;
        end
    endtask

    task automatic modelBeat(input logic [C_W-1:0] d, input logic last);
        frameQ.push_back(d);
        if (last) begin
            if (frameQ.size() == C_NUM) begin
                for (int i = 0; i < C_NUM; i++) modelShadow[i] = frameQ[i];
                modelPending = 1'b1;
            end else begin
                expErr = 1'b1;
            end
            frameQ.delete();
        end
    endtask

    task automatic modelApply();
        for (int i = 0; i < C_NUM; i++) modelActive[i] = modelShadow[i];
        modelSwaps   = modelSwaps + 1;
        modelPending = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        logic                 expReady;
        logic [7:0]           expSwap;
        logic [C_NUM*C_W-1:0] expCoeff;
        expReady = ~modelPending;
        expSwap  = 8'(modelSwaps);
        expCoeff = packActive();
        total++;
        assert (bus.s_ready === expReady) else begin
            bad++;
            $error("FAIL %s s_ready observed=%0b expected=%0b", tag, bus.s_ready, expReady);
        end
        total++;
        assert (loadDone === modelPending) else begin
            bad++;
            $error("FAIL %s load_done observed=%0b expected=%0b", tag, loadDone, modelPending);
        end
        total++;
        assert (err === expErr) else begin
            bad++;
            $error("FAIL %s err observed=%0b expected=%0b", tag, err, expErr);
        end
        total++;
        assert (swapCount === expSwap) else begin
            bad++;
            $error("FAIL %s swap_count observed=%0d expected=%0d", tag, swapCount, expSwap);
        end
        total++;
        assert (coeffOut === expCoeff) else begin
            bad++;
            $error("FAIL %s coeff_out observed=%h expected=%h", tag, coeffOut, expCoeff);
        end
    endtask

    // One clock edge with whatever inputs are currently driven, then model and check
    task automatic applyStimulus(input string tag);
        logic           acc;
        logic           ap;
        logic [C_W-1:0] d;
        logic           last;
        acc  = bus.s_valid && !modelPending;
        ap   = apply && modelPending;
        d    = bus.s_data;
        last = bus.s_last;
        @(posedge clock);
        #1;
        expErr = 1'b0;
        if (ap) modelApply();
        else if (acc) modelBeat(d, last);
        checkOutput(tag);
    endtask

    task automatic sendFrame(input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.s_valid = 1'b0;
                    bus.s_data  = C_W'($urandom);
                    bus.s_last  = 1'($urandom);
                    applyStimulus("gap");
                end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = frameData[i];
            bus.s_last  = (i == len - 1);
            applyStimulus("beat");
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic pulseApply(input string tag);
        apply = 1'b1;
        applyStimulus(tag);
        apply = 1'b0;
    endtask

    task automatic randomFrame();
        for (int i = 0; i < 64; i++) frameData[i] = C_W'($urandom);
    endtask

    // Directed sequence of scenarios
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        apply       = 1'b0;
        reset       = 1'b1;
        #2;
        reset = 1'b0;
        modelReset();
        #2;
        checkOutput("reset");
        repeat (2) @(posedge clock);
        #4;
        reset = 1'b1;
        applyStimulus("postReset");

        // Basic frame 1..33, held without apply, then a single apply
        for (int i = 0; i < 64; i++) frameData[i] = C_W'(i + 1);
        sendFrame(C_NUM, 0);
        repeat (3) applyStimulus("pendingHold");
        pulseApply("apply1");
        applyStimulus("afterApply1");

        // Short frame followed immediately by a valid frame
        for (int i = 0; i < 64; i++) frameData[i] = C_W'(16'h0100 + i);
        sendFrame(10, 0);
        randomFrame();
        sendFrame(C_NUM, 0);
        pulseApply("apply2");

        // Long frame: excess beats discarded, apply must do nothing
        randomFrame();
        sendFrame(40, 0);
        applyStimulus("afterLong");
        pulseApply("applyIgnored");

        // Extreme values with apply held high through the whole load
        randomFrame();
        frameData[0]  = 16'h8000;
        frameData[32] = 16'h7FFF;
        frameData[16] = 16'hED3C;
        apply = 1'b1;
        sendFrame(C_NUM, 0);
        applyStimulus("heldApplySwap");
        apply = 1'b0;
        applyStimulus("afterHeldApply");

        // Reset in the middle of a frame after earlier swaps
        randomFrame();
        sendFrame(20, 1);
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("midFrameReset");
        #1;
        reset = 1'b1;
        applyStimulus("releaseReset");
        randomFrame();
        sendFrame(C_NUM, 1);
        pulseApply("applyAfterReset");

        // Backpressure: second frame offered while pending is held off until apply
        randomFrame();
        sendFrame(C_NUM, 1);
        randomFrame();
        bus.s_valid = 1'b1;
        bus.s_data  = frameData[0];
        bus.s_last  = 1'b0;
        repeat (3) applyStimulus("blocked");
        pulseApply("applyWhileOffered");
        sendFrame(C_NUM, 1);
        pulseApply("applySecond");
        repeat (2) applyStimulus("tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
